inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction queue `fifo`. It:
- generates sequential byte PCs;
- issues requests to a synchronous (1-cycle latency) instruction memory;
- pushes `{pc, inst}` entries into the queue.

It never writes the queue while the queue's `full_o` is asserted, and parks at most one returning instruction in a hold register. Branch redirects from the back end discard all in-flight and held work.

---
 rtl/inst_fetch.sv | 128 ++++++++++++
 tb/tb_inst_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC generation, 1-cycle-latency imem requests,
// and {pc, inst} delivery into the downstream queue with a single-entry hold buffer.
module inst_fetch #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         CNT_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic                           redirect_valid_i,
  input  logic [PC_WIDTH-1:0]            redirect_pc_i,
  output logic                           imem_req_o,
  output logic [PC_WIDTH-1:0]            imem_addr_o,
  input  logic [INST_WIDTH-1:0]          imem_rdata_i,
  input  logic                           fifo_full_i,
  output logic                           fifo_wr_o,
  output logic [PC_WIDTH+INST_WIDTH-1:0] fifo_data_o,
  output logic [CNT_WIDTH-1:0]           fetch_cnt_o
);

  localparam int unsigned         DATA_W  = PC_WIDTH + INST_WIDTH;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INST_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  pend_q, pend_d;
  logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  flush;
  logic                  issue;
  logic                  wr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     resp_entry;

  assign flush      = reset_i || redirect_valid_i;
  assign resp_entry = {pend_pc_q, imem_rdata_i};

  // State register; reset drops pending responses and the held entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, issue and queue-write decisions.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    wr        = 1'b0;
    wr_data   = '0;

    if (!flush) begin
      issue = (state_q == S_RUN) && !fifo_full_i;

      // A returning instruction either goes straight to the queue or parks in hold.
      if (pend_q) begin
        if (!fifo_full_i) begin
          wr      = 1'b1;
          wr_data = resp_entry;
        end else begin
          hold_d  = resp_entry;
          state_d = S_HOLD;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) state_d = S_RUN;
        end
        S_HOLD: begin
          if (!fifo_full_i) begin
            wr      = 1'b1;
            wr_data = hold_q;
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end else if (redirect_valid_i) begin
      // Redirect discards in-flight and held work; IDLE is not left by a redirect.
      pc_d   = redirect_pc_i;
      hold_d = '0;
      if (state_q != S_IDLE) state_d = S_RUN;
    end

    if (issue) begin
      pc_d      = pc_q + PC_STEP;
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
    end

    if (wr) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign fifo_wr_o   = wr;
  assign fifo_data_o = wr_data;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then random full/redirect/reset
// traffic, checked every cycle against a behavioural model and a program-order tracker.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic        clk;
  logic        reset_i;
  logic        start_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        fifo_full_i;
  logic        fifo_wr_o;
  logic [63:0] fifo_data_o;
  logic [31:0] fetch_cnt_o;

  inst_fetch #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .RESET_PC  (RST_PC),
    .CNT_WIDTH (32)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .fifo_full_i     (fifo_full_i),
    .fifo_wr_o       (fifo_wr_o),
    .fifo_data_o     (fifo_data_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  bit          m_known = 1'b0;
  int          m_mode  = M_IDLE;
  logic [31:0] m_pc    = RST_PC;
  bit          m_pend  = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [63:0] m_hold  = '0;
  logic [31:0] m_cnt   = '0;
  logic [31:0] next_prog_pc = RST_PC;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model and memory.
  task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] rpc, input bit fl);
    bit          e_req, e_wr;
    logic [63:0] e_data;
    bit          req_s;
    logic [31:0] addr_s;

    @(negedge clk);
    reset_i = rst; start_i = st; redirect_valid_i = rd; redirect_pc_i = rpc; fifo_full_i = fl;
    #1;

    e_req  = !rst && !rd && (m_mode == M_RUN) && !fl;
    e_wr   = 1'b0;
    e_data = '0;
    if (!rst && !rd && !fl) begin
      if (m_pend) begin
        e_wr = 1'b1; e_data = {m_pend_pc, mem(m_pend_pc)};
      end else if (m_mode == M_HOLD) begin
        e_wr = 1'b1; e_data = m_hold;
      end
    end

    chk("imem_req", 64'(imem_req_o), 64'(e_req));
    chk("fifo_wr", 64'(fifo_wr_o), 64'(e_wr));
    chk("fifo_data", fifo_data_o, e_data);
    if (m_known && !rst) begin
      chk("imem_addr", 64'(imem_addr_o), 64'(m_pc));
      chk("fetch_cnt", 64'(fetch_cnt_o), 64'(m_cnt));
    end
    if (e_wr) begin
      chk("prog_order_pc", 64'(fifo_data_o[63:32]), 64'(next_prog_pc));
      next_prog_pc = next_prog_pc + 32'd4;
    end
    req_s  = imem_req_o;
    addr_s = imem_addr_o;

    if (rst) begin
      m_known = 1'b1; m_mode = M_IDLE; m_pc = RST_PC; m_pend = 1'b0;
      m_hold = '0; m_cnt = '0; next_prog_pc = RST_PC;
    end else if (rd) begin
      m_pc = rpc; m_pend = 1'b0; next_prog_pc = rpc;
      if (m_mode != M_IDLE) m_mode = M_RUN;
    end else begin
      if (m_pend && fl) begin
        m_mode = M_HOLD; m_hold = {m_pend_pc, mem(m_pend_pc)};
      end else if (m_mode == M_HOLD && !fl) begin
        m_mode = M_RUN;
      end else if (m_mode == M_IDLE && st) begin
        m_mode = M_RUN;
      end
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
      if (e_wr) m_cnt = m_cnt + 32'd1;
    end

    @(posedge clk);
    #1;
    imem_rdata_i = req_s ? mem(addr_s) : $urandom;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = '0; fifo_full_i = 1'b0; imem_rdata_i = '0;

    // t0..t1 reset, t2 start, stream to t9, full t10..t14, stream afterwards
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 3; i <= 9; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 10; i <= 14; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 15; i <= 20; i++) cyc(0, 0, 0, 0, 0);

    // Redirect during a response cycle
    cyc(0, 0, 1, 32'h0000_2000, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Enter HOLD, then redirect while holding
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h0000_3000, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // PC wrap-around
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    // Reset while in HOLD; stays IDLE until start, redirect beats start in IDLE
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h0000_4000, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          r_rst, r_st, r_rd, r_fl;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(99) < 1);
      r_st  = ($urandom_range(99) < 20);
      r_rd  = ($urandom_range(99) < 6);
      r_fl  = ($urandom_range(99) < 30);
      r_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(3) * 4))
                                       : ($urandom & 32'hFFFF_FFFC);
      cyc(r_rst, r_st, r_rd, r_pc, r_fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
